// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command sequencer.
//   - keyboard command bytes sent by the host
//   - keyboard response bytes recognised by the host
//   - controller state enumeration
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [3:0] {
    ST_RST_SEND,
    ST_RST_ACK,
    ST_BAT_WAIT,
    ST_IDLE,
    ST_LED_CMD,
    ST_LED_CMD_ACK,
    ST_LED_DATA,
    ST_LED_DATA_ACK,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Response timeout counter.
//   clk     : system clock
//   reset   : asynchronous, active-high
//   clear   : force count to zero (wins over enable)
//   enable  : count one cycle
//   expired : count has reached TIMEOUT_CYCLES-1 while enabled
module ps2_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Wrap after the last count so an expiry overridden by a received byte
  // re-arms a full period instead of running off into a long wrap.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable)
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 keyboard host command sequencer.
//   clk, reset          : system clock, asynchronous active-high reset
//   rx_done_tick/rx_data: received byte strobe and data
//   tx_idle             : transmitter can accept a byte
//   tx_start/tx_data    : registered transmit strobe and held byte
//   rx_en               : receiver enable (tx_idle & ~tx_start)
//   led_req/led_state   : requested / acknowledged LEDs {caps,num,scroll}
//   key_valid/key_code  : registered forwarded scan code strobe
//   init_done/fault     : sticky self-test pass / protocol failure flags
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       tx_idle,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       rx_en,
  input  logic [2:0] led_req,
  output logic [2:0] led_state,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       init_done,
  output logic       fault
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    led_state_q, led_state_d;
  logic [2:0]    led_pend_q, led_pend_d;
  logic          force_led_q, force_led_d;
  logic          init_done_q, init_done_d;
  logic          fault_q, fault_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_code_q, key_code_d;

  logic   retry_evt;
  state_e resend_st;
  logic   wait_q, wait_d;
  logic   timer_clear, expired;

  function automatic logic is_wait(input state_e s);
    return (s == ST_RST_ACK) || (s == ST_BAT_WAIT) ||
           (s == ST_LED_CMD_ACK) || (s == ST_LED_DATA_ACK);
  endfunction

  assign wait_q      = is_wait(state_q);
  assign wait_d      = is_wait(state_d);
  assign timer_clear = wait_d && (state_d != state_q);

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (wait_q),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    led_state_d = led_state_q;
    led_pend_d  = led_pend_q;
    force_led_d = force_led_q;
    init_done_d = init_done_q;
    fault_d     = fault_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    retry_evt   = 1'b0;
    resend_st   = ST_RST_SEND;

    case (state_q)
      ST_RST_SEND: if (tx_idle) begin
        tx_start_d = 1'b1;
        tx_data_d  = CMD_RESET;
        state_d    = ST_RST_ACK;
      end

      ST_RST_ACK: begin
        resend_st = ST_RST_SEND;
        if (rx_done_tick) begin
          if (rx_data == RSP_ACK) begin
            retry_d = '0;
            state_d = ST_BAT_WAIT;
          end else if (rx_data == RSP_RESEND) begin
            retry_evt = 1'b1;
          end
        end else if (expired) begin
          retry_evt = 1'b1;
        end
      end

      ST_BAT_WAIT: begin
        resend_st = ST_RST_SEND;
        if (rx_done_tick) begin
          if (rx_data == RSP_BAT_OK) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (rx_data == RSP_BAT_FAIL) begin
            state_d = ST_FAULT;
          end
        end else if (expired) begin
          retry_evt = 1'b1;
        end
      end

      ST_IDLE: begin
        // A hot-plug self-test holds off the LED check for one cycle so the
        // cleared led_state and the force flag are both visible next cycle.
        if (rx_done_tick && rx_data == RSP_BAT_OK) begin
          led_state_d = '0;
          force_led_d = 1'b1;
        end else begin
          if (rx_done_tick && rx_data != RSP_ACK && rx_data != RSP_RESEND) begin
            key_valid_d = 1'b1;
            key_code_d  = rx_data;
          end
          if (force_led_q || led_req != led_state_q) begin
            led_pend_d  = led_req;
            force_led_d = 1'b0;
            state_d     = ST_LED_CMD;
          end
        end
      end

      ST_LED_CMD: if (tx_idle) begin
        tx_start_d = 1'b1;
        tx_data_d  = CMD_SET_LED;
        state_d    = ST_LED_CMD_ACK;
      end

      ST_LED_CMD_ACK: begin
        resend_st = ST_LED_CMD;
        if (rx_done_tick) begin
          if (rx_data == RSP_ACK) begin
            retry_d = '0;
            state_d = ST_LED_DATA;
          end else if (rx_data == RSP_RESEND) begin
            retry_evt = 1'b1;
          end
        end else if (expired) begin
          retry_evt = 1'b1;
        end
      end

      ST_LED_DATA: if (tx_idle) begin
        tx_start_d = 1'b1;
        tx_data_d  = {5'b0, led_pend_q};
        state_d    = ST_LED_DATA_ACK;
      end

      ST_LED_DATA_ACK: begin
        resend_st = ST_LED_DATA;
        if (rx_done_tick) begin
          if (rx_data == RSP_ACK) begin
            retry_d     = '0;
            led_state_d = led_pend_q;
            state_d     = ST_IDLE;
          end else if (rx_data == RSP_RESEND) begin
            retry_evt = 1'b1;
          end
        end else if (expired) begin
          retry_evt = 1'b1;
        end
      end

      ST_FAULT: if (rx_done_tick && rx_data != RSP_BAT_OK) begin
        key_valid_d = 1'b1;
        key_code_d  = rx_data;
      end

      default: state_d = ST_RST_SEND;
    endcase

    if (retry_evt) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = resend_st;
      end else begin
        state_d = ST_FAULT;
      end
    end

    if (state_d == ST_IDLE) retry_d = '0;
    if (state_d == ST_FAULT) fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_SEND;
      retry_q     <= '0;
      led_state_q <= '0;
      led_pend_q  <= '0;
      force_led_q <= 1'b0;
      init_done_q <= 1'b0;
      fault_q     <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      led_state_q <= led_state_d;
      led_pend_q  <= led_pend_d;
      force_led_q <= force_led_d;
      init_done_q <= init_done_d;
      fault_q     <= fault_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign rx_en     = tx_idle & ~tx_start_q & ~reset;
  assign led_state = led_state_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign init_done = init_done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Self-checking bench for ps2_host_ctrl: scoreboard queues for transmitted
// bytes and forwarded key codes, plus a simple transmitter busy model.
module tb_ps2_host_ctrl;

  localparam int unsigned TO   = 1000;
  localparam int unsigned MAXR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_idle = 1'b1;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_en;
  logic [2:0] led_req = '0;
  logic [2:0] led_state;
  logic       key_valid;
  logic [7:0] key_code;
  logic       init_done;
  logic       fault;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_q[$];
  logic [7:0] key_q[$];
  longint unsigned tx_times[$];
  longint unsigned cyc = 0;

  always #5 clk = ~clk;

  ps2_host_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_idle(tx_idle), .tx_start(tx_start), .tx_data(tx_data), .rx_en(rx_en),
    .led_req(led_req), .led_state(led_state), .key_valid(key_valid),
    .key_code(key_code), .init_done(init_done), .fault(fault)
  );

  // Scoreboard monitor plus transmitter model (busy 10 cycles per byte).
  task automatic mon_tx_key();
    logic [7:0] e;
    int busy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start === 1'b1) begin
        tx_times.push_back(cyc);
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected: tx_data=%02h, expected no transmit", tx_data);
        end else begin
          e = tx_q.pop_front();
          if (tx_data !== e) begin
            failures++;
            $display("FAIL tx_byte: tx_data=%02h, expected %02h", tx_data, e);
          end
        end
      end
      if (key_valid === 1'b1) begin
        checks++;
        if (key_q.size() == 0) begin
          failures++;
          $display("FAIL key_unexpected: key_code=%02h, expected no key_valid", key_code);
        end else begin
          e = key_q.pop_front();
          if (key_code !== e) begin
            failures++;
            $display("FAIL key_code: key_code=%02h, expected %02h", key_code, e);
          end
        end
      end
      if (busy > 0) begin
        busy--;
        if (busy == 0) tx_idle = 1'b1;
      end else if (tx_start === 1'b1) begin
        tx_idle = 1'b0;
        busy = 10;
      end
    end
  endtask

  task automatic mon_rx_en();
    logic exp;
    forever begin
      @(posedge clk);
      #2;
      exp = ~reset & tx_idle & ~tx_start;
      checks++;
      if (rx_en !== exp) begin
        failures++;
        $display("FAIL rx_en: rx_en=%0b, expected %0b", rx_en, exp);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit fwd);
    if (fwd) key_q.push_back(b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    checks++;
    if (key_valid !== fwd || (fwd && key_code !== b)) begin
      failures++;
      $display("FAIL rx_fwd_%02h: key_valid=%0b key_code=%02h, expected key_valid=%0b",
               b, key_valid, key_code, fwd);
    end
  endtask

  task automatic reply(input logic [7:0] b);
    for (int i = 0; i < 100 && tx_idle !== 1'b1; i++) @(negedge clk);
    send_rx(b, 1'b0);
  endtask

  task automatic wait_drained(input int budget, input string name);
    for (int i = 0; i < budget && tx_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (tx_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d transmits outstanding, expected 0", name, tx_q.size());
      tx_q.delete();
    end
  endtask

  task automatic bring_up();
    reset = 1'b1;
    led_req = 3'b000;
    wait_cycles(2);
    tx_q.push_back(8'hFF);
    reset = 1'b0;
    wait_drained(40, "bringup_ff");
    reply(8'hFA);
    reply(8'hAA);
    wait_cycles(3);
    checks++;
    if (init_done !== 1'b1 || fault !== 1'b0) begin
      failures++;
      $display("FAIL bringup: init_done=%0b fault=%0b, expected 1 0", init_done, fault);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    wait_cycles(3);
    checks++;
    if ({tx_start, tx_data, rx_en, led_state, key_valid, key_code, init_done, fault} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: tx_start=%0b tx_data=%02h rx_en=%0b led=%03b kv=%0b kc=%02h init=%0b fault=%0b, expected all 0",
               tx_start, tx_data, rx_en, led_state, key_valid, key_code, init_done, fault);
    end
  endtask

  task automatic test_powerup();
    tx_q.push_back(8'hFF);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hFF) begin
      failures++;
      $display("FAIL powerup_latency: tx_start=%0b tx_data=%02h, expected 1 ff", tx_start, tx_data);
    end
    wait_drained(5, "powerup_ff");
    reply(8'hFA);
    checks++;
    if (init_done !== 1'b0) begin
      failures++;
      $display("FAIL init_early: init_done=%0b, expected 0", init_done);
    end
    reply(8'hAA);
    wait_cycles(20);
    checks++;
    if (init_done !== 1'b1 || led_state !== 3'b000 || fault !== 1'b0) begin
      failures++;
      $display("FAIL powerup_done: init=%0b led=%03b fault=%0b, expected 1 000 0", init_done, led_state, fault);
    end
  endtask

  task automatic test_led();
    tx_q.push_back(8'hED);
    led_req = 3'b100;
    wait_drained(20, "led_ed");
    tx_q.push_back(8'h04);
    reply(8'hFA);
    wait_drained(20, "led_data");
    reply(8'hFA);
    wait_cycles(2);
    checks++;
    if (led_state !== 3'b100) begin
      failures++;
      $display("FAIL led_state_100: led_state=%03b, expected 100", led_state);
    end
    send_rx(8'h1C, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_rx(8'h1C, 1'b1);
    send_rx(8'h32, 1'b1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hFE, 1'b0);
    send_rx(8'h5A, 1'b1);
    wait_cycles(5);
  endtask

  task automatic test_resend();
    tx_q.push_back(8'hED);
    led_req = 3'b010;
    wait_drained(20, "resend_ed0");
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'hED);
      reply(8'hFE);
      wait_drained(20, "resend_ed");
    end
    tx_q.push_back(8'h02);
    reply(8'hFA);
    wait_drained(20, "resend_data");
    reply(8'hFA);
    wait_cycles(2);
    checks++;
    if (led_state !== 3'b010 || fault !== 1'b0) begin
      failures++;
      $display("FAIL resend_ok: led=%03b fault=%0b, expected 010 0", led_state, fault);
    end
    tx_q.push_back(8'hED);
    led_req = 3'b011;
    wait_drained(20, "exhaust_ed0");
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'hED);
      reply(8'hFE);
      wait_drained(20, "exhaust_ed");
    end
    reply(8'hFE);
    wait_cycles(30);
    checks++;
    if (fault !== 1'b1 || led_state !== 3'b010) begin
      failures++;
      $display("FAIL resend_fault: fault=%0b led=%03b, expected 1 010", fault, led_state);
    end
  endtask

  task automatic test_fault_forward();
    send_rx(8'h1C, 1'b1);
    send_rx(8'hAA, 1'b0);
    send_rx(8'hFA, 1'b1);
    wait_cycles(20);
    checks++;
    if (fault !== 1'b1 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky: fault=%0b init=%0b, expected 1 1", fault, init_done);
    end
  endtask

  task automatic test_timeout();
    longint unsigned fault_cyc = 0;
    reset = 1'b1;
    led_req = 3'b000;
    wait_cycles(2);
    tx_times.delete();
    tx_q.push_back(8'hFF);
    reset = 1'b0;
    wait_drained(20, "timeout_ff0");
    for (int i = 0; i < 3; i++) tx_q.push_back(8'hFF);
    wait_drained(3 * (TO + 50), "timeout_resends");
    for (int i = 0; i < TO + 50 && fault !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    fault_cyc = cyc;
    checks++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fault: fault=%0b, expected 1", fault);
    end
    checks++;
    if (tx_times.size() != 4) begin
      failures++;
      $display("FAIL timeout_sends: sends=%0d, expected 4", tx_times.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (tx_times[i] - tx_times[i-1] != longint'(TO + 1)) begin
          failures++;
          $display("FAIL timeout_interval: interval=%0d, expected %0d", tx_times[i] - tx_times[i-1], TO + 1);
        end
      end
      checks++;
      if (fault_cyc - tx_times[3] != longint'(TO)) begin
        failures++;
        $display("FAIL timeout_fault_time: delay=%0d, expected %0d", fault_cyc - tx_times[3], TO);
      end
    end
    wait_cycles(20);
  endtask

  task automatic test_stray_and_change();
    bring_up();
    tx_q.push_back(8'hED);
    led_req = 3'b100;
    wait_drained(20, "stray_ed");
    reply(8'h1C);
    tx_q.push_back(8'h04);
    reply(8'hFA);
    wait_drained(20, "stray_data");
    led_req = 3'b101;
    tx_q.push_back(8'hED);
    reply(8'hFA);
    checks++;
    if (led_state !== 3'b100) begin
      failures++;
      $display("FAIL change_first: led_state=%03b, expected 100", led_state);
    end
    wait_drained(20, "change_ed");
    tx_q.push_back(8'h05);
    reply(8'hFA);
    wait_drained(20, "change_data");
    reply(8'hFA);
    wait_cycles(2);
    checks++;
    if (led_state !== 3'b101) begin
      failures++;
      $display("FAIL change_second: led_state=%03b, expected 101", led_state);
    end
  endtask

  task automatic test_hotplug();
    send_rx(8'h29, 1'b1);
    tx_q.push_back(8'hED);
    send_rx(8'hAA, 1'b0);
    checks++;
    if (led_state !== 3'b000) begin
      failures++;
      $display("FAIL hotplug_clear: led_state=%03b, expected 000", led_state);
    end
    wait_drained(20, "hotplug_ed");
    tx_q.push_back(8'h05);
    reply(8'hFA);
    wait_drained(20, "hotplug_data");
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_start, tx_data, rx_en, led_state, key_valid, key_code, init_done, fault} !== '0) begin
      failures++;
      $display("FAIL midseq_reset: tx_start=%0b tx_data=%02h rx_en=%0b led=%03b kv=%0b kc=%02h init=%0b fault=%0b, expected all 0",
               tx_start, tx_data, rx_en, led_state, key_valid, key_code, init_done, fault);
    end
    wait_cycles(2);
    tx_q.push_back(8'hFF);
    reset = 1'b0;
    wait_drained(40, "restart_ff");
    wait_cycles(5);
  endtask

  initial begin
    fork
      mon_tx_key();
      mon_rx_en();
    join_none
    test_reset();
    test_powerup();
    test_led();
    test_back_to_back();
    test_resend();
    test_fault_forward();
    test_timeout();
    test_stray_and_change();
    test_hotplug();
    checks++;
    if (tx_q.size() != 0 || key_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: tx pending=%0d key pending=%0d, expected 0 0", tx_q.size(), key_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
